retire_unit: RTL and testbench
==============================

RETIRE_UNIT -- requirements
Module: retire_unit

Interface
REQ-001 Parameter FREE_Q_DEPTH, default 4, is the depth of the freed-register queue; it SHALL be a power of two, minimum 2.
REQ-002 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 Port commit_valid, input, 1: the ROB head entry is ready to commit.
REQ-005 Port commit_dest, input, 6: physical destination of the committing entry.
REQ-006 Port commit_old_dest, input, 6: previous physical mapping of the same architectural register, to be freed.
REQ-007 Port commit_value, input, 32: result value of the committing entry.
REQ-008 Port commit_ready, output, 1: the unit accepts a commit this cycle.
REQ-009 Port retire_valid, output, 1: retire_phys_reg holds a physical register to return to the rename free list.
REQ-010 Port retire_phys_reg, output, 6: the physical register being freed.
REQ-011 Port retire_ready, input, 1: the rename free list accepts the freed register this cycle.
REQ-012 Port prf_wr_en, output, 1: register-file write strobe.
REQ-013 Port prf_wr_addr, output, 6: register-file write address.
REQ-014 Port prf_wr_data, output, 32: register-file write data.
REQ-015 Port flush_req, input, 1: request to stop commits and drain the free queue.
REQ-016 Port flush_done, output, 1: one-cycle pulse indicating the drain has completed.
REQ-017 Port retired_count, output, 16: count of committed instructions.

Function
REQ-018 The unit SHALL implement three states:
- RUN
- DRAIN
- DONE
REQ-019 commit_ready SHALL be 1 only when the state is RUN and the queue occupancy is less than FREE_Q_DEPTH; it is combinational from registered state, and a same-cycle pop SHALL NOT be used to raise it.
REQ-020 A commit SHALL be accepted at a rising edge where commit_valid=1 and commit_ready=1.
REQ-021 On an accepted commit, commit_old_dest SHALL be pushed into the queue, except when commit_old_dest=0, which SHALL be dropped (physical register 0 is never freed).
REQ-022 The cycle after an accepted commit, the register-file write SHALL be presented with 1-cycle latency:
- prf_wr_en=1
- prf_wr_addr=commit_dest
- prf_wr_data=commit_value
REQ-023 prf_wr_en SHALL be 0 in every other cycle, and SHALL also be 0 after an accepted commit whose commit_dest=0.
REQ-024 retired_count SHALL increment by 1 on each accepted commit and SHALL saturate at 16'hFFFF.
REQ-025 retire_valid SHALL equal (occupancy != 0), and retire_phys_reg SHALL show the queue head.
REQ-026 The queue head SHALL be popped at an edge where retire_valid=1 and retire_ready=1.
REQ-027 Simultaneous push and pop SHALL leave the occupancy unchanged and SHALL preserve FIFO order.
REQ-028 Queue read and write pointers SHALL wrap modulo FREE_Q_DEPTH.
REQ-029 A pop from an empty queue and a push to a full queue SHALL be impossible by construction.
REQ-030 RUN SHALL transition to DRAIN on an edge where flush_req=1; a commit handshaking at that same edge SHALL still be accepted.
REQ-031 In DRAIN, commit_ready SHALL be 0, and pops SHALL continue per REQ-026.
REQ-032 DRAIN SHALL transition to DONE at the edge where the occupancy becomes 0, or on the next edge if the occupancy is already 0.
REQ-033 In DONE, flush_done SHALL be 1 for exactly one cycle, and the state SHALL then return to RUN unconditionally.
REQ-034 flush_req SHALL be ignored outside the RUN state.

Reset
REQ-035 While reset_n=0, and asynchronously on its assertion, the unit SHALL hold:
- state=RUN
- occupancy=0 and both queue pointers=0
- retire_valid=0, retire_phys_reg=0
- prf_wr_en=0, prf_wr_addr=0, prf_wr_data=0
- flush_done=0
- retired_count=0
REQ-036 Reset asserted mid-DRAIN or with a non-empty queue SHALL discard all queued entries, with no retire_valid pulse after release.
REQ-037 commit_ready SHALL be 1 in the first cycle after reset_n deasserts.

Verification
REQ-038 The bench SHALL cover a single commit: commit_valid=1, dest=5, old_dest=1, value=32'hDEADBEEF, retire_ready=1 -> next cycle prf_wr_en=1, addr=5, data=DEADBEEF, and retire_valid=1 with retire_phys_reg=1; retired_count=1.
REQ-039 The bench SHALL cover backpressure: retire_ready=0 with 5 commits offered (old_dest 1..5, DEPTH=4) -> 4 accepted, then commit_ready=0; raising retire_ready returns 1,2,3,4 in order, and the 5th commit is then accepted.
REQ-040 The bench SHALL cover the register-0 filter: a commit with dest=0, old_dest=0 -> no prf_wr_en, no queue push, and retired_count still increments.
REQ-041 The bench SHALL cover a flush: 3 entries queued, flush_req pulsed, retire_ready=1 -> commit_ready=0 during DRAIN, 3 pops, then flush_done high for exactly 1 cycle, then commit_ready=1.
REQ-042 The bench SHALL cover reset mid-DRAIN: 2 entries queued, in DRAIN, reset_n=0 -> retire_valid=0 immediately (asynchronously), and after release the unit is in RUN with occupancy 0.
REQ-043 The bench SHALL cover wrap-around with simultaneous push and pop: continuous commits with retire_ready=1 over 10 cycles -> occupancy stays at 1 or below, the sequence of freed registers matches the sequence of commits, and the pointers wrap correctly.

Source files
------------

// File: rtl/retire_unit.sv
// Retire unit: accepts commits from the ROB head, writes results to the
// physical register file one cycle later, and queues the superseded physical
// registers for return to the rename free list. A flush stops new commits,
// drains the free queue, and pulses flush_done once the queue is empty.
module retire_unit #(
   parameter int FREE_Q_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        commit_valid,
   input  logic [5:0]  commit_dest,
   input  logic [5:0]  commit_old_dest,
   input  logic [31:0] commit_value,
   output logic        commit_ready,
   output logic        retire_valid,
   output logic [5:0]  retire_phys_reg,
   input  logic        retire_ready,
   output logic        prf_wr_en,
   output logic [5:0]  prf_wr_addr,
   output logic [31:0] prf_wr_data,
   input  logic        flush_req,
   output logic        flush_done,
   output logic [15:0] retired_count
);

   localparam int PW = (FREE_Q_DEPTH > 1) ? $clog2(FREE_Q_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FREE_Q_DEPTH);

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t         state;
   logic [5:0]     mem [FREE_Q_DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           accept;
   logic           push;
   logic           pop;

   // Handshakes derive only from registered state, so a same-cycle pop
   // never opens room for a commit, which rules out pushing into a full
   // queue and popping an empty one.
   assign commit_ready    = (state == RUN) && (count < DEPTH_C);
   assign accept          = commit_valid && commit_ready;
   assign push            = accept && (commit_old_dest != 6'd0);
   assign retire_valid    = (count != '0);
   assign pop             = retire_valid && retire_ready;
   assign retire_phys_reg = retire_valid ? mem[rd_ptr] : 6'd0;

   // Control FSM with registered flush_done, high for the single DONE cycle.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RUN;
         flush_done <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         case (state)
            RUN: begin
               if (flush_req) state <= DRAIN;
            end
            DRAIN: begin
               if ((count == '0) || (pop && (count == CW'(1)))) begin
                  state      <= DONE;
                  flush_done <= 1'b1;
               end
            end
            DONE:    state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   // Queue storage; the contents are only visible through the occupancy.
   // NOTE: the storage array is deliberately not reset; emptiness is carried
   // by count, so stale entries are never exposed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= commit_old_dest;
   end

   // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Register-file write port, one cycle behind the accepted commit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prf_wr_en   <= 1'b0;
         prf_wr_addr <= 6'd0;
         prf_wr_data <= 32'd0;
      end else begin
         prf_wr_en <= accept && (commit_dest != 6'd0);
         if (accept) begin
            prf_wr_addr <= commit_dest;
            prf_wr_data <= commit_value;
         end
      end
   end

   // Saturating count of committed instructions.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retired_count <= 16'd0;
      end else if (accept && (retired_count != 16'hFFFF)) begin
         retired_count <= retired_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit: reset, single commit, backpressure,
// register-0 filtering, flushes, wrap-around streaming and reset mid-drain.
module tb_retire_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        commit_valid;
   logic [5:0]  commit_dest;
   logic [5:0]  commit_old_dest;
   logic [31:0] commit_value;
   logic        commit_ready;
   logic        retire_valid;
   logic [5:0]  retire_phys_reg;
   logic        retire_ready;
   logic        prf_wr_en;
   logic [5:0]  prf_wr_addr;
   logic [31:0] prf_wr_data;
   logic        flush_req;
   logic        flush_done;
   logic [15:0] retired_count;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [15:0] exp_count = 16'd0;

   retire_unit #(.FREE_Q_DEPTH(4)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .commit_valid    (commit_valid),
      .commit_dest     (commit_dest),
      .commit_old_dest (commit_old_dest),
      .commit_value    (commit_value),
      .commit_ready    (commit_ready),
      .retire_valid    (retire_valid),
      .retire_phys_reg (retire_phys_reg),
      .retire_ready    (retire_ready),
      .prf_wr_en       (prf_wr_en),
      .prf_wr_addr     (prf_wr_addr),
      .prf_wr_data     (prf_wr_data),
      .flush_req       (flush_req),
      .flush_done      (flush_done),
      .retired_count   (retired_count)
   );

   always #5 clk = ~clk;

   // Advance one clock; everything is driven and sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n         = 1'b0;
      commit_valid    = 1'b0;
      commit_dest     = 6'd0;
      commit_old_dest = 6'd0;
      commit_value    = 32'd0;
      retire_ready    = 1'b0;
      flush_req       = 1'b0;
      repeat (2) tick();
      tests_run++;
      if (retire_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_retire_valid got %b exp 0", retire_valid); end
      tests_run++;
      if (retire_phys_reg !== 6'd0) begin tests_failed++; $display("FAIL reset_phys_reg got %0d exp 0", retire_phys_reg); end
      tests_run++;
      if ({prf_wr_en, prf_wr_addr, prf_wr_data} !== 39'd0) begin tests_failed++; $display("FAIL reset_prf got en=%b addr=%0d data=%h exp all 0", prf_wr_en, prf_wr_addr, prf_wr_data); end
      tests_run++;
      if (flush_done !== 1'b0) begin tests_failed++; $display("FAIL reset_flush_done got %b exp 0", flush_done); end
      tests_run++;
      if (retired_count !== 16'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", retired_count); end
      reset_n = 1'b1;
      tick();
      tests_run++;
      if (commit_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_commit_ready got %b exp 1", commit_ready); end
      exp_count = 16'd0;
   endtask

   task automatic test_single_commit();
      commit_valid    = 1'b1;
      commit_dest     = 6'd5;
      commit_old_dest = 6'd1;
      commit_value    = 32'hDEADBEEF;
      retire_ready    = 1'b1;
      tick();
      commit_valid = 1'b0;
      exp_count++;
      tests_run++;
      if ({prf_wr_en, prf_wr_addr, prf_wr_data} !== {1'b1, 6'd5, 32'hDEADBEEF}) begin tests_failed++; $display("FAIL single_prf got en=%b addr=%0d data=%h exp en=1 addr=5 data=deadbeef", prf_wr_en, prf_wr_addr, prf_wr_data); end
      tests_run++;
      if ({retire_valid, retire_phys_reg} !== {1'b1, 6'd1}) begin tests_failed++; $display("FAIL single_retire got v=%b reg=%0d exp v=1 reg=1", retire_valid, retire_phys_reg); end
      tests_run++;
      if (retired_count !== exp_count) begin tests_failed++; $display("FAIL single_count got %0d exp %0d", retired_count, exp_count); end
      tick();
      tests_run++;
      if ({retire_valid, prf_wr_en} !== 2'b00) begin tests_failed++; $display("FAIL single_after got v=%b wr_en=%b exp 0 0", retire_valid, prf_wr_en); end
   endtask

   task automatic test_backpressure();
      retire_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         commit_valid    = 1'b1;
         commit_dest     = 6'(i + 8);
         commit_old_dest = 6'(i);
         commit_value    = 32'(i);
         tests_run++;
         if (commit_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_%0d got %b exp 1", i, commit_ready); end
         tick();
         exp_count++;
      end
      commit_old_dest = 6'd5;
      commit_dest     = 6'd13;
      retire_ready    = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tests_run++;
         if ({retire_valid, retire_phys_reg} !== {1'b1, 6'(k)}) begin tests_failed++; $display("FAIL bp_order_%0d got v=%b reg=%0d exp v=1 reg=%0d", k, retire_valid, retire_phys_reg, k); end
         if (k == 1) begin
            tests_run++;
            if (commit_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full_ready got %b exp 0", commit_ready); end
         end
         if (k == 2) begin
            tests_run++;
            if (commit_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_reopen_ready got %b exp 1", commit_ready); end
            exp_count++;
         end
         tick();
         if (k == 2) commit_valid = 1'b0;
      end
      tests_run++;
      if (retire_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_empty got %b exp 0", retire_valid); end
      tests_run++;
      if (retired_count !== exp_count) begin tests_failed++; $display("FAIL bp_count got %0d exp %0d", retired_count, exp_count); end
   endtask

   task automatic test_reg0_filter();
      commit_valid    = 1'b1;
      commit_dest     = 6'd0;
      commit_old_dest = 6'd0;
      commit_value    = 32'h0000_0123;
      tick();
      commit_valid = 1'b0;
      exp_count++;
      tests_run++;
      if ({prf_wr_en, retire_valid} !== 2'b00) begin tests_failed++; $display("FAIL reg0_filter got wr_en=%b v=%b exp 0 0", prf_wr_en, retire_valid); end
      tests_run++;
      if (retired_count !== exp_count) begin tests_failed++; $display("FAIL reg0_count got %0d exp %0d", retired_count, exp_count); end
   endtask

   task automatic test_flush();
      retire_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         commit_valid    = 1'b1;
         commit_dest     = 6'(20 + i);
         commit_old_dest = 6'(10 + i);
         commit_value    = 32'(i);
         flush_req       = (i == 2);
         tests_run++;
         if (commit_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_fill_ready_%0d got %b exp 1", i, commit_ready); end
         tick();
         exp_count++;
      end
      commit_valid = 1'b0;
      flush_req    = 1'b0;
      retire_ready = 1'b1;
      tests_run++;
      if (retired_count !== exp_count) begin tests_failed++; $display("FAIL flush_edge_commit got %0d exp %0d", retired_count, exp_count); end
      for (int k = 0; k < 3; k++) begin
         tests_run++;
         if ({commit_ready, flush_done, retire_valid, retire_phys_reg} !== {1'b0, 1'b0, 1'b1, 6'(10 + k)}) begin
            tests_failed++;
            $display("FAIL flush_drain_%0d got rdy=%b done=%b v=%b reg=%0d exp 0 0 1 %0d", k, commit_ready, flush_done, retire_valid, retire_phys_reg, 10 + k);
         end
         tick();
      end
      tests_run++;
      if ({flush_done, commit_ready, retire_valid} !== 3'b100) begin tests_failed++; $display("FAIL flush_done_pulse got done=%b rdy=%b v=%b exp 1 0 0", flush_done, commit_ready, retire_valid); end
      tick();
      tests_run++;
      if ({flush_done, commit_ready} !== 2'b01) begin tests_failed++; $display("FAIL flush_back_run got done=%b rdy=%b exp 0 1", flush_done, commit_ready); end
   endtask

   task automatic test_flush_empty();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      tests_run++;
      if ({flush_done, commit_ready} !== 2'b00) begin tests_failed++; $display("FAIL flush_empty_drain got done=%b rdy=%b exp 0 0", flush_done, commit_ready); end
      flush_req = 1'b1;
      tick();
      tests_run++;
      if ({flush_done, commit_ready} !== 2'b10) begin tests_failed++; $display("FAIL flush_empty_done got done=%b rdy=%b exp 1 0", flush_done, commit_ready); end
      flush_req = 1'b0;
      tick();
      tests_run++;
      if ({flush_done, commit_ready} !== 2'b01) begin tests_failed++; $display("FAIL flush_empty_run got done=%b rdy=%b exp 0 1", flush_done, commit_ready); end
   endtask

   task automatic test_back_to_back();
      retire_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         commit_valid    = 1'b1;
         commit_dest     = 6'(40 + i);
         commit_old_dest = 6'(i + 1);
         commit_value    = 32'(i);
         tests_run++;
         if (commit_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_%0d got %b exp 1", i, commit_ready); end
         tick();
         exp_count++;
         tests_run++;
         if ({retire_valid, retire_phys_reg, prf_wr_en, prf_wr_addr, prf_wr_data} !== {1'b1, 6'(i + 1), 1'b1, 6'(40 + i), 32'(i)}) begin
            tests_failed++;
            $display("FAIL b2b_step_%0d got v=%b reg=%0d en=%b addr=%0d data=%h exp v=1 reg=%0d en=1 addr=%0d data=%h",
                     i, retire_valid, retire_phys_reg, prf_wr_en, prf_wr_addr, prf_wr_data, i + 1, 40 + i, i);
         end
      end
      commit_valid = 1'b0;
      tick();
      tests_run++;
      if ({retire_valid, prf_wr_en} !== 2'b00) begin tests_failed++; $display("FAIL b2b_end got v=%b en=%b exp 0 0", retire_valid, prf_wr_en); end
      tests_run++;
      if (retired_count !== exp_count) begin tests_failed++; $display("FAIL b2b_count got %0d exp %0d", retired_count, exp_count); end
   endtask

   task automatic test_reset_mid_drain();
      retire_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         commit_valid    = 1'b1;
         commit_dest     = 6'(50 + i);
         commit_old_dest = 6'(30 + i);
         commit_value    = 32'(i);
         tick();
      end
      commit_valid = 1'b0;
      flush_req    = 1'b1;
      tick();
      flush_req = 1'b0;
      tests_run++;
      if ({retire_valid, commit_ready} !== 2'b10) begin tests_failed++; $display("FAIL rst_drain_setup got v=%b rdy=%b exp 1 0", retire_valid, commit_ready); end
      #2 reset_n = 1'b0;
      #1;
      tests_run++;
      if ({retire_valid, retire_phys_reg, retired_count} !== {1'b0, 6'd0, 16'd0}) begin
         tests_failed++;
         $display("FAIL rst_async got v=%b reg=%0d count=%0d exp 0 0 0", retire_valid, retire_phys_reg, retired_count);
      end
      tick();
      #2 reset_n = 1'b1;
      retire_ready = 1'b1;
      tick();
      tests_run++;
      if ({commit_ready, retire_valid, flush_done} !== 3'b100) begin tests_failed++; $display("FAIL rst_release got rdy=%b v=%b done=%b exp 1 0 0", commit_ready, retire_valid, flush_done); end
      tick();
      tests_run++;
      if (retire_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_no_stale got %b exp 0", retire_valid); end
   endtask

   initial begin
      test_reset();
      test_single_commit();
      test_backpressure();
      test_reg0_filter();
      test_flush();
      test_flush_empty();
      test_back_to_back();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
